// File: rtl/e_mdu_ctrl_pkg.sv
// Shared E-stage multiply/divide constants: md_op encodings, FSM states, latencies.
// MDU_MADD_EN adds MADD/MADDU to the multi-cycle operation class.
package e_mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MFHI  = 4'd6,
    OP_MFLO  = 4'd7,
    OP_MADD  = 4'd8,
    OP_MADDU = 4'd9
  } mdOpE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mduStateE;

  localparam int MUL_CYCLES = 5;
  localparam int DIV_CYCLES = 10;

  // Counter reload values: the commit edge is the one where the counter reads 0.
  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_CNT_INIT = 4'(DIV_CYCLES - 1);

  function automatic logic isMdClass(input logic [3:0] op);
    logic cls;
    cls = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    cls = cls || (op == OP_MADD) || (op == OP_MADDU);
`endif
    return cls;
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational MDU arithmetic: 64-bit product (or accumulate), quotient/remainder.
// Accumulate path exists only with MDU_MADD_EN defined.
module e_mdu_calc
  import e_mdu_ctrl_pkg::*;
(
  input  logic [3:0]  mdOp,
  input  logic [31:0] rsData,
  input  logic [31:0] rtData,
  input  logic [31:0] hiIn,
  input  logic [31:0] loIn,
  output logic [63:0] mulRes,
  output logic [63:0] divRes
);

  logic        signedOp;
  logic [63:0] aExt, bExt, prod;
  logic        rsNeg, rtNeg, divZero;
  logic [31:0] rsMag, rtMag, divisor, quoMag, remMag, quo, rem;

  always_comb begin
    signedOp = (mdOp == OP_MULT) || (mdOp == OP_DIV) || (mdOp == OP_MADD);

    aExt = signedOp ? {{32{rsData[31]}}, rsData} : {32'd0, rsData};
    bExt = signedOp ? {{32{rtData[31]}}, rtData} : {32'd0, rtData};
    prod = aExt * bExt;
`ifdef MDU_MADD_EN
    mulRes = ((mdOp == OP_MADD) || (mdOp == OP_MADDU)) ? ({hiIn, loIn} + prod) : prod;
`else
    mulRes = prod;
`endif

    // Magnitude division avoids the 0x80000000 / -1 overflow; negating back wraps correctly.
    rsNeg   = signedOp && rsData[31];
    rtNeg   = signedOp && rtData[31];
    rsMag   = rsNeg ? -rsData : rsData;
    rtMag   = rtNeg ? -rtData : rtData;
    divZero = (rtData == 32'd0);
    divisor = divZero ? 32'd1 : rtMag;
    quoMag  = rsMag / divisor;
    remMag  = rsMag % divisor;
    quo     = (rsNeg ^ rtNeg) ? -quoMag : quoMag;
    rem     = rsNeg ? -remMag : remMag;
    divRes  = divZero ? {hiIn, loIn} : {rem, quo};
  end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide control: FSM, down-counter, shadow and committed HI/LO.
// Define MDU_MADD_EN to enable MADD/MADDU accumulate.
//
// state   | meaning
// IDLE    | accepts start: MT* write HI/LO directly, MULT/DIV class latches shadow
// MUL     | multiply in flight, commits shadow when counter reaches 0
// DIV     | divide in flight, commits shadow when counter reaches 0
module e_mdu_ctrl
  import e_mdu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        exc_flush,
  output logic        busy,
  output logic        mdStart,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  mduStateE    state, stateNext;
  logic [3:0]  cnt, cntNext;
  logic [31:0] shadowHi, shadowLo, shadowHiNext, shadowLoNext;
  logic [31:0] hiNext, loNext;
  logic [63:0] mulRes, divRes;

  e_mdu_calc uCalc (
    .mdOp   (md_op),
    .rsData (rs_data),
    .rtData (rt_data),
    .hiIn   (hi),
    .loIn   (lo),
    .mulRes (mulRes),
    .divRes (divRes)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      shadowHi <= 32'd0;
      shadowLo <= 32'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      shadowHi <= shadowHiNext;
      shadowLo <= shadowLoNext;
      hi       <= hiNext;
      lo       <= loNext;
    end
  end

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    shadowHiNext = shadowHi;
    shadowLoNext = shadowLo;
    hiNext       = hi;
    loNext       = lo;
    case (state)
      ST_IDLE: begin
        if (start && !exc_flush) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              {shadowHiNext, shadowLoNext} = mulRes;
              cntNext   = MUL_CNT_INIT;
              stateNext = ST_MUL;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
              {shadowHiNext, shadowLoNext} = mulRes;
              cntNext   = MUL_CNT_INIT;
              stateNext = ST_MUL;
            end
`endif
            OP_DIV, OP_DIVU: begin
              {shadowHiNext, shadowLoNext} = divRes;
              cntNext   = DIV_CNT_INIT;
              stateNext = ST_DIV;
            end
            OP_MTHI: hiNext = rs_data;
            OP_MTLO: loNext = rs_data;
            default: ;
          endcase
        end
      end
      // New requests are ignored here; flush cannot cancel an issued older op.
      ST_MUL, ST_DIV: begin
        if (cnt == 4'd0) begin
          hiNext    = shadowHi;
          loNext    = shadowLo;
          stateNext = ST_IDLE;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  assign busy    = (state != ST_IDLE);
  assign mdStart = start && isMdClass(md_op) && !exc_flush;
  assign rd_data = (md_op == OP_MFHI) ? hi : ((md_op == OP_MFLO) ? lo : 32'd0);

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Scoreboard bench for e_mdu_ctrl: stimulus queues expected commits, a monitor checks them.
// Honors MDU_MADD_EN the same way the RTL does.
module tb_e_mdu_ctrl;
  import e_mdu_ctrl_pkg::*;

  logic        clk, reset, start, exc_flush;
  logic [3:0]  md_op;
  logic [31:0] rs_data, rt_data;
  logic        busy, mdStart;
  logic [31:0] hi, lo, rd_data;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  len;
  } expT;

  expT sbQ[$];
  int  checks = 0;
  int  failures = 0;

  e_mdu_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .exc_flush (exc_flush),
    .busy      (busy),
    .mdStart   (mdStart),
    .hi        (hi),
    .lo        (lo),
    .rd_data   (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic expectCommit(input logic [31:0] h, input logic [31:0] l, input int len);
    expT e;
    e.hi  = h;
    e.lo  = l;
    e.len = 8'(len);
    sbQ.push_back(e);
  endtask

  // Drives one request for a single rising edge; returns at the following negedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic flush, input logic expStart);
    @(negedge clk);
    start = 1'b1; md_op = op; rs_data = a; rt_data = b; exc_flush = flush;
    #1;
    check("mdStart", 32'(mdStart), 32'(expStart));
    @(negedge clk);
    start = 1'b0; exc_flush = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL wait_idle actual=busy required=idle within 60 cycles");
    end
    @(negedge clk);
  endtask

  // Monitor: every busy->idle transition is a commit to be matched against the queue.
  initial begin
    logic prevBusy;
    int   busyCnt;
    expT  e;
    prevBusy = 1'b0;
    busyCnt  = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prevBusy = 1'b0;
        busyCnt  = 0;
      end else begin
        if (busy) busyCnt++;
        else if (prevBusy) begin
          if (sbQ.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_commit actual=hi 0x%08h lo 0x%08h required=no commit", hi, lo);
          end else begin
            e = sbQ.pop_front();
            check("sb_hi", hi, e.hi);
            check("sb_lo", lo, e.lo);
            check("sb_busy_len", 32'(busyCnt), 32'(e.len));
          end
          busyCnt = 0;
        end
        prevBusy = busy;
      end
    end
  end

  initial begin
    reset = 1'b0; start = 1'b0; exc_flush = 1'b0;
    md_op = OP_MFHI; rs_data = 32'd0; rt_data = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    reset = 1'b1;

    expectCommit(32'hFFFFFFFF, 32'hFFFFFFFE, MUL_CYCLES);
    issue(OP_MULT, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b1);
    waitIdle();

    expectCommit(32'h00000001, 32'hFFFFFFFE, MUL_CYCLES);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b1);
    waitIdle();

    expectCommit(32'hFFFFFFFF, 32'hFFFFFFFD, DIV_CYCLES);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1);
    waitIdle();

    expectCommit(32'hFFFFFFFF, 32'hFFFFFFFD, DIV_CYCLES);
    issue(OP_DIVU, 32'd7, 32'd0, 1'b0, 1'b1);
    waitIdle();

    expectCommit(32'h00000000, 32'h80000000, DIV_CYCLES);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1);
    waitIdle();

    // Flushed start: nothing may happen.
    issue(OP_MULT, 32'd3, 32'd3, 1'b1, 1'b0);
    @(negedge clk);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_hi", hi, 32'h00000000);
    check("flush_lo", lo, 32'h80000000);

    // Flush rising mid-divide must not cancel the older op.
    expectCommit(32'd2, 32'd14, DIV_CYCLES);
    issue(OP_DIV, 32'd100, 32'd7, 1'b0, 1'b1);
    @(negedge clk);
    exc_flush = 1'b1;
    repeat (2) @(negedge clk);
    exc_flush = 1'b0;
    waitIdle();

    expectCommit(32'h0000000F, 32'h0FFFFFFF, DIV_CYCLES);
    issue(OP_DIVU, 32'hFFFFFFFF, 32'h10, 1'b0, 1'b1);
    waitIdle();

    // MTLO while busy is dropped; lo must carry the product.
    expectCommit(32'd0, 32'd15, MUL_CYCLES);
    issue(OP_MULT, 32'd3, 32'd5, 1'b0, 1'b1);
    start = 1'b1; md_op = OP_MTLO; rs_data = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    waitIdle();

    issue(OP_MTLO, 32'h12345678, 32'd0, 1'b0, 1'b0);
    check("mtlo_lo", lo, 32'h12345678);
    check("mtlo_busy", 32'(busy), 32'd0);
    md_op = OP_MFLO; #1;
    check("mflo_rd", rd_data, 32'h12345678);
    issue(OP_MTHI, 32'h0000CAFE, 32'd0, 1'b0, 1'b0);
    check("mthi_hi", hi, 32'h0000CAFE);
    md_op = OP_MFHI; #1;
    check("mfhi_rd", rd_data, 32'h0000CAFE);
    md_op = OP_MULT; #1;
    check("other_rd", rd_data, 32'd0);

    // Reset mid-multiply discards the pending result.
    issue(OP_MULT, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    @(negedge clk);
    @(negedge clk);
    expectCommit(32'd0, 32'd12, MUL_CYCLES);
    reset = 1'b1; start = 1'b1; md_op = OP_MULT; rs_data = 32'd3; rt_data = 32'd4;
    @(negedge clk);
    start = 1'b0;
    check("post_rst_busy", 32'(busy), 32'd1);
    waitIdle();

    issue(OP_MTHI, 32'd0, 32'd0, 1'b0, 1'b0);
    issue(OP_MTLO, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0);
`ifdef MDU_MADD_EN
    expectCommit(32'd1, 32'd0, MUL_CYCLES);
    issue(OP_MADDU, 32'd1, 32'd1, 1'b0, 1'b1);
    waitIdle();
`else
    issue(OP_MADDU, 32'd1, 32'd1, 1'b0, 1'b0);
    check("madd_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("madd_hi", hi, 32'd0);
    check("madd_lo", lo, 32'hFFFFFFFF);
`endif

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sbQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
